// File: rtl/registro_pkg.sv
// Shared operation codes for the universal shift register family.
package registro_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b110;

endpackage

// File: rtl/registro_universal_n_if.sv
// Control/data bundle between a datapath master and the universal register.
interface registro_universal_n_if
    import registro_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              CE;
    logic [MODE_W-1:0] MODE;
    logic [WIDTH-1:0]  DATA_IN;
    logic              SERIAL_IN_L;
    logic              SERIAL_IN_R;
    logic [WIDTH-1:0]  DATA_OUT;
    logic              SERIAL_OUT_L;
    logic              SERIAL_OUT_R;
    logic [CNT_W-1:0]  SHIFT_CNT;
    logic              FULL;

    modport master (
        output CE, MODE, DATA_IN, SERIAL_IN_L, SERIAL_IN_R,
        input  DATA_OUT, SERIAL_OUT_L, SERIAL_OUT_R, SHIFT_CNT, FULL
    );

    modport slave (
        input  CE, MODE, DATA_IN, SERIAL_IN_L, SERIAL_IN_R,
        output DATA_OUT, SERIAL_OUT_L, SERIAL_OUT_R, SHIFT_CNT, FULL
    );

endinterface

// File: rtl/registro_universal_celda.sv
// One storage bit of the universal register: CE/RESET cell extended with
// neighbour inputs so a chain of these shifts and rotates.
module registro_universal_celda
    import registro_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic [MODE_W-1:0] MODE,
    input  logic              left_nb,
    input  logic              right_nb,
    input  logic              data_bit,
    input  logic              reset_bit,
    output logic              q
);

    // SHL/ROL pull from the lower-index neighbour, SHR/ROR from the higher one;
    // the top decides what the edge cells see as neighbours.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q <= reset_bit;
        end else if (CE) begin
            case (MODE)
                MODE_HOLD:          q <= q;
                MODE_LOAD:          q <= data_bit;
                MODE_SHL, MODE_ROL: q <= right_nb;
                MODE_SHR, MODE_ROR: q <= left_nb;
                MODE_CLEAR:         q <= reset_bit;
                default:            q <= q;
            endcase
        end
    end

endmodule

// File: rtl/registro_universal_n.sv
// N-bit universal register: hold/load/shift/rotate/clear with a saturating
// count of shifts since the last load, clear or reset.
module registro_universal_n
    import registro_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                  CLK,
    input logic                  RESET,
    registro_universal_n_if.slave bus
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             full;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic right_nb;
        logic left_nb;

        // Edge cells see either the serial input or the opposite end (rotate).
        if (i == 0) begin : g_lsb
            assign right_nb = (bus.MODE == MODE_ROL) ? q[WIDTH-1] : bus.SERIAL_IN_L;
        end else begin : g_mid_r
            assign right_nb = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign left_nb = (bus.MODE == MODE_ROR) ? q[0] : bus.SERIAL_IN_R;
        end else begin : g_mid_l
            assign left_nb = q[i+1];
        end

        registro_universal_celda u_celda (
            .CLK       (CLK),
            .RESET     (RESET),
            .CE        (bus.CE),
            .MODE      (bus.MODE),
            .left_nb   (left_nb),
            .right_nb  (right_nb),
            .data_bit  (bus.DATA_IN[i]),
            .reset_bit (RESET_VALUE[i]),
            .q         (q[i])
        );
    end

    always_comb begin
        cnt_next = cnt;
        if (bus.CE) begin
            case (bus.MODE)
                MODE_LOAD, MODE_CLEAR: cnt_next = '0;
                MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: begin
                    if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
                end
                default: cnt_next = cnt;
            endcase
        end
    end

    // FULL is registered from the next count so it never lags SHIFT_CNT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            full <= (cnt_next == CNT_MAX);
        end
    end

    assign bus.DATA_OUT     = q;
    assign bus.SERIAL_OUT_L = q[WIDTH-1];
    assign bus.SERIAL_OUT_R = q[0];
    assign bus.SHIFT_CNT    = cnt;
    assign bus.FULL         = full;

endmodule
